// File: rtl/sha1_wb_buffer.sv
// Write-back buffer between the SHA-1 accelerator and the data-memory write port.
// Queues digest words, drains them via req/gnt, holds the pipeline and flags digest commit.
module sha1_wb_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WORDS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        word_valid_i,
    input  logic [31:0] word_i,
    input  logic [31:0] word_addr_i,
    input  logic        flush_i,
    input  logic        mem_gnt_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        hold_o,
    output logic        done_o,
    output logic        overflow_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned ENT_W = 64;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(WORDS - 1);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WC_W-1:0]  wc_q, wc_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic             full_c;
    logic             pop_c;
    logic             push_c;
    logic [ENT_W-1:0] head_c;

    // Request is derived from registered occupancy only; grant never reaches an output.
    assign full_c     = (cnt_q == FULL_CNT);
    assign mem_req_o  = (cnt_q != '0);
    assign mem_we_o   = mem_req_o;
    assign pop_c      = mem_req_o && mem_gnt_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_c     = word_valid_i && (!full_c || pop_c);

    assign head_c     = mem_q[rd_ptr_q];
    assign mem_addr_o = head_c[63:32];
    assign mem_data_o = head_c[31:0];

    assign hold_o     = (cnt_q != '0) || word_valid_i || (wc_q != '0);
    assign done_o     = done_q;
    assign overflow_o = ovf_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        wc_d     = wc_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            wc_d     = '0;
            ovf_d    = 1'b0;
        end else begin
            // Address is stored word-aligned so the head can drive the port directly.
            if (push_c) begin
                mem_d[wr_ptr_q] = {word_addr_i & 32'hFFFF_FFFC, word_i};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else if (word_valid_i) begin
                ovf_d = 1'b1;
            end

            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                if (wc_q == WC_LAST) begin
                    wc_d   = '0;
                    done_d = 1'b1;
                end else begin
                    wc_d = wc_q + WC_W'(1);
                end
            end

            case ({push_c, pop_c})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            wc_q     <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            wc_q     <= wc_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sha1_wb_buffer.sv
// Directed bench for sha1_wb_buffer: a DEPTH=8 instance (a_*) and a DEPTH=4 instance (b_*).
module tb_sha1_wb_buffer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_valid, a_flush, a_gnt;
    logic [31:0] a_word, a_addr;
    logic        a_req, a_we, a_hold, a_done, a_ovf;
    logic [31:0] a_maddr, a_mdata;

    logic        b_valid, b_flush, b_gnt;
    logic [31:0] b_word, b_addr;
    logic        b_req, b_we, b_hold, b_done, b_ovf;
    logic [31:0] b_maddr, b_mdata;

    sha1_wb_buffer #(.DEPTH(8), .WORDS(5)) u_a (
        .clk(clk), .rst(rst),
        .word_valid_i(a_valid), .word_i(a_word), .word_addr_i(a_addr),
        .flush_i(a_flush), .mem_gnt_i(a_gnt),
        .mem_req_o(a_req), .mem_we_o(a_we), .mem_addr_o(a_maddr), .mem_data_o(a_mdata),
        .hold_o(a_hold), .done_o(a_done), .overflow_o(a_ovf)
    );

    sha1_wb_buffer #(.DEPTH(4), .WORDS(5)) u_b (
        .clk(clk), .rst(rst),
        .word_valid_i(b_valid), .word_i(b_word), .word_addr_i(b_addr),
        .flush_i(b_flush), .mem_gnt_i(b_gnt),
        .mem_req_o(b_req), .mem_we_o(b_we), .mem_addr_o(b_maddr), .mem_data_o(b_mdata),
        .hold_o(b_hold), .done_o(b_done), .overflow_o(b_ovf)
    );

    typedef struct {
        logic        v;
        logic [31:0] w;
        logic [31:0] a;
        logic        g;
        logic        req;
        logic        chk_ad;
        logic [31:0] ea;
        logic [31:0] ed;
        logic        hold;
        logic        done;
    } vec_t;

    vec_t tbl [8];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Checks port-A outputs for one cycle; addr/data compared only when a request is expected.
    task automatic chk_a(input string tag, input logic req, input logic chk_ad,
                         input logic [31:0] ea, input logic [31:0] ed,
                         input logic hold, input logic done, input logic ovf);
        chk({tag, " req"}, 32'(a_req), 32'(req));
        chk({tag, " we"}, 32'(a_we), 32'(req));
        if (chk_ad) begin
            chk({tag, " addr"}, a_maddr, ea);
            chk({tag, " data"}, a_mdata, ed);
        end
        chk({tag, " hold"}, 32'(a_hold), 32'(hold));
        chk({tag, " done"}, 32'(a_done), 32'(done));
        chk({tag, " ovf"}, 32'(a_ovf), 32'(ovf));
    endtask

    task automatic chk_b(input string tag, input logic req, input logic chk_ad,
                         input logic [31:0] ea, input logic [31:0] ed,
                         input logic hold, input logic done, input logic ovf);
        chk({tag, " req"}, 32'(b_req), 32'(req));
        if (chk_ad) begin
            chk({tag, " addr"}, b_maddr, ea);
            chk({tag, " data"}, b_mdata, ed);
        end
        chk({tag, " hold"}, 32'(b_hold), 32'(hold));
        chk({tag, " done"}, 32'(b_done), 32'(done));
        chk({tag, " ovf"}, 32'(b_ovf), 32'(ovf));
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 8; i++) begin
            a_valid = tbl[i].v;
            a_word  = tbl[i].w;
            a_addr  = tbl[i].a;
            a_gnt   = tbl[i].g;
            a_flush = 1'b0;
            @(negedge clk);
            chk_a($sformatf("%s c%0d", tag, i), tbl[i].req, tbl[i].chk_ad,
                  tbl[i].ea, tbl[i].ed, tbl[i].hold, tbl[i].done, 1'b0);
            next_cycle();
        end
    endtask

    initial begin
        // Basic drain: five words back to back, grant always high.
        tbl[0] = '{1'b1, 32'h1111_1111, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,         1'b1, 1'b0};
        tbl[1] = '{1'b1, 32'h2222_2222, 32'h104, 1'b1, 1'b1, 1'b1, 32'h100, 32'h1111_1111, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 32'h3333_3333, 32'h108, 1'b1, 1'b1, 1'b1, 32'h104, 32'h2222_2222, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 32'h4444_4444, 32'h10C, 1'b1, 1'b1, 1'b1, 32'h108, 32'h3333_3333, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 32'h5555_5555, 32'h110, 1'b1, 1'b1, 1'b1, 32'h10C, 32'h4444_4444, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 32'h0,         32'h0,   1'b1, 1'b1, 1'b1, 32'h110, 32'h5555_5555, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 32'h0,         32'h0,   1'b1, 1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b1};
        tbl[7] = '{1'b0, 32'h0,         32'h0,   1'b1, 1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b0};

        rst = 1'b1;
        a_valid = 1'b0; a_word = '0; a_addr = '0; a_flush = 1'b0; a_gnt = 1'b0;
        b_valid = 1'b0; b_word = '0; b_addr = '0; b_flush = 1'b0; b_gnt = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk_a("reset a", 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_b("reset b", 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        next_cycle();

        run_table("drain");

        // Stalled grant: head held stable for ten cycles, then drains.
        for (int c = 0; c < 16; c++) begin
            a_valid = (c < 5);
            a_word  = 32'h1111_1111 * (c + 1);
            a_addr  = 32'h100 + 32'(4 * c);
            a_gnt   = (c >= 10);
            @(negedge clk);
            if (c == 0)
                chk_a($sformatf("stall c%0d", c), 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            else if (c <= 10)
                chk_a($sformatf("stall c%0d", c), 1'b1, 1'b1, 32'h100, 32'h1111_1111, 1'b1, 1'b0, 1'b0);
            else if (c < 15)
                chk_a($sformatf("stall c%0d", c), 1'b1, 1'b1, 32'h100 + 32'(4 * (c - 10)),
                      32'h1111_1111 * (c - 9), 1'b1, 1'b0, 1'b0);
            else
                chk_a($sformatf("stall c%0d", c), 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
            next_cycle();
        end

        // Flush after two writes; the word offered in the flush cycle is discarded.
        for (int c = 0; c < 7; c++) begin
            a_valid = (c < 4);
            a_word  = 32'h1111_1111 * (c + 1);
            a_addr  = 32'h100 + 32'(4 * c);
            a_gnt   = 1'b1;
            a_flush = (c == 3);
            @(negedge clk);
            if (c >= 1 && c <= 3)
                chk_a($sformatf("flush c%0d", c), 1'b1, 1'b1, 32'h100 + 32'(4 * (c - 1)),
                      32'h1111_1111 * c, 1'b1, 1'b0, 1'b0);
            else if (c >= 4)
                chk_a($sformatf("flush c%0d", c), 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end
        a_flush = 1'b0;
        run_table("post-flush");

        // DEPTH=4 overflow: fifth word dropped, only four writes, wc left at 4.
        for (int c = 0; c < 11; c++) begin
            b_valid = (c < 5);
            b_word  = 32'h1111_1111 * (c + 1);
            b_addr  = 32'h100 + 32'(4 * c);
            b_gnt   = (c >= 5);
            @(negedge clk);
            if (c == 0)
                chk_b($sformatf("ovf c%0d", c), 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            else if (c <= 4)
                chk_b($sformatf("ovf c%0d", c), 1'b1, 1'b1, 32'h100, 32'h1111_1111, 1'b1, 1'b0, 1'b0);
            else if (c <= 8)
                chk_b($sformatf("ovf c%0d", c), 1'b1, 1'b1, 32'h100 + 32'(4 * (c - 5)),
                      32'h1111_1111 * (c - 4), 1'b1, 1'b0, 1'b1);
            else
                chk_b($sformatf("ovf c%0d", c), 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
            next_cycle();
        end

        b_valid = 1'b0; b_gnt = 1'b0; b_flush = 1'b1;
        next_cycle();
        b_flush = 1'b0;
        @(negedge clk);
        chk_b("ovf flushed", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        next_cycle();

        // Full FIFO with push and pop together: push accepted, no overflow, five commits.
        for (int c = 0; c < 10; c++) begin
            b_valid = (c < 5);
            b_word  = (c == 4) ? 32'hAAAA_AAAA : 32'h1111_1111 * (c + 1);
            b_addr  = (c == 4) ? 32'h200 : 32'h100 + 32'(4 * c);
            b_gnt   = (c >= 4);
            @(negedge clk);
            if (c >= 4 && c <= 7)
                chk_b($sformatf("fullpp c%0d", c), 1'b1, 1'b1, 32'h100 + 32'(4 * (c - 4)),
                      32'h1111_1111 * (c - 3), 1'b1, 1'b0, 1'b0);
            else if (c == 8)
                chk_b($sformatf("fullpp c%0d", c), 1'b1, 1'b1, 32'h200, 32'hAAAA_AAAA, 1'b1, 1'b0, 1'b0);
            else if (c == 9)
                chk_b($sformatf("fullpp c%0d", c), 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
            next_cycle();
        end
        b_valid = 1'b0; b_gnt = 1'b0;

        // Reset with three words queued, then a misaligned address.
        for (int c = 0; c < 3; c++) begin
            a_valid = 1'b1;
            a_word  = 32'h7777_0000 + 32'(c);
            a_addr  = 32'h300 + 32'(4 * c);
            a_gnt   = 1'b0;
            next_cycle();
        end
        a_valid = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk_a("midrst", 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        next_cycle();

        a_valid = 1'b1; a_word = 32'hDEAD_BEEF; a_addr = 32'h103;
        next_cycle();
        a_valid = 1'b0;
        @(negedge clk);
        chk_a("misalign", 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha1_wb_buffer.md
# sha1_wb_buffer

Write-back buffer directly downstream of the SHA-1 accelerator in the EX stage. It accepts the five digest words the accelerator emits, one per cycle with its destination address, queues them in a small FIFO, and drains them into the data-memory write port through a request/grant handshake. It raises a pipeline hold while any digest word is still in flight, and pulses `done_o` once a full digest has been committed to memory.

## Interface
Parameters:
- `DEPTH`, default 8. FIFO entries. Must be a power of 2 and at least 2.
- `WORDS`, default 5. Words per digest; sets when `done_o` fires.

Ports:
- `clk`, input, 1. Clock.
- `rst`, input, 1. Reset; synchronous, active-high.
- `word_valid_i`, input, 1. Digest word present this cycle (the accelerator's write-phase strobe).
- `word_i`, input, 32. Digest word.
- `word_addr_i`, input, 32. Destination byte address of `word_i`.
- `flush_i`, input, 1. Abort from pipeline (jump or exception); synchronous.
- `mem_gnt_i`, input, 1. Memory arbiter grant; core stores have priority, so grant may be withheld any number of cycles.
- `mem_req_o`, output, 1. Write request.
- `mem_we_o`, output, 1. Write enable; equals `mem_req_o`.
- `mem_addr_o`, output, 32. Write address; bits [1:0] forced to 0.
- `mem_data_o`, output, 32. Write data.
- `hold_o`, output, 1. Stall request to the pipeline.
- `done_o`, output, 1. One-cycle pulse per committed digest.
- `overflow_o`, output, 1. Sticky flag: a word was dropped because the FIFO was full.

## Operation
- **Storage:** DEPTH×64-bit register array holding {addr, data}. Write pointer, read pointer, and an occupancy count `cnt` of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- **Push:** occurs when `word_valid_i && cnt != DEPTH`. Writes {`word_addr_i`, `word_i`} at the write pointer, then increments it.
- **Full:** `word_valid_i` with `cnt == DEPTH` drops the word and sets `overflow_o`. Nothing else changes.
- **Pop:** occurs when `mem_req_o && mem_gnt_i`. Read pointer increments; the head entry is retired.
- **Simultaneous push and pop:** `cnt` is unchanged. This also holds when full: the pop frees a slot, so the push is accepted and no overflow occurs.
- **Empty:** `mem_req_o = mem_we_o = 0`. `mem_addr_o` and `mem_data_o` still show the head entry (don't-care).
- **Commit counter `wc`** (0..WORDS-1):
  - Increments on each pop.
  - On the pop where `wc == WORDS-1`, `wc` returns to 0 and `done_o` pulses the following cycle.
- **Hold:** `hold_o = (cnt != 0) || word_valid_i || (wc != 0)`. The pipeline therefore stays stalled across gaps inside a digest.
- **Flush:** `flush_i` has priority over push and pop in the same cycle. It clears the pointers, `cnt`, `wc`, `done_o` and `overflow_o`. No memory request is issued in the flush cycle's outcome; a pending grant in that cycle is ignored.
- **Reset:** `rst` has the same effect as flush. Reset values:
  - `mem_req_o = mem_we_o = 0`
  - `mem_addr_o = 0`, `mem_data_o = 0` (storage cleared)
  - `hold_o = 0`, `done_o = 0`, `overflow_o = 0`

## Timing
- **Push to request:** a word pushed at edge t appears on `mem_req_o`/`mem_addr_o`/`mem_data_o` after edge t. There is no same-cycle bypass. Minimum latency from `word_valid_i` to request is 1 cycle.
- **Request outputs:** `mem_req_o` is a combinational function of registered `cnt`. `mem_addr_o` and `mem_data_o` come from the registered head entry. There is no combinational path from `mem_gnt_i` to any output.
- **Throughput:** with `mem_gnt_i` held at 1, one word retires per cycle. A 5-word burst arriving on consecutive cycles retires on cycles 1..5; `done_o` pulses on cycle 6.
- **Handshake:** while `mem_req_o = 1` and `mem_gnt_i = 0`, address and data are held stable.
- **Done:** `done_o` is registered and high exactly one cycle.
- **Hold release:** `hold_o` drops combinationally in the cycle after the final pop.

## Test plan
- **Basic drain:** push 0x11111111..0x55555555 to addresses 0x100..0x110 on 5 consecutive cycles, with `mem_gnt_i = 1`. Expect five writes in order, each address paired with its data, on cycles 1..5. `done_o` pulses on cycle 6; `hold_o` is 0 from cycle 6.
- **Stalled grant:** same stimulus, with `mem_gnt_i = 0` for 10 cycles, then 1. Expect `mem_req_o = 1` with addr 0x100 / data 0x11111111 stable throughout. Then 5 writes, then `done_o`. `overflow_o` stays 0.
- **Overflow:** DEPTH=4, grant 0, push 5 words. Expect `cnt = 4`, `overflow_o = 1`, and word 5 lost. With grant restored, only 4 writes occur and `done_o` does not pulse. `hold_o` stays 1 because `wc = 4`.
- **Full with simultaneous push and pop:** DEPTH=4, full FIFO, grant=1 and push in the same cycle. Expect the push accepted, `cnt` unchanged at 4, and no overflow.
- **Flush mid-drain:** assert `flush_i` after 2 writes. Next cycle expect `mem_req_o = 0`, `hold_o = 0`, and no `done_o`. A fresh 5-word digest then completes normally.
- **Reset mid-operation and misaligned address:** `rst` with 3 words queued gives all outputs 0. Pushing to address 0x103 produces `mem_addr_o = 0x100`.
